// File: rtl/mips_exec_unit.sv
// Execute stage of the single-cycle MIPS CPU. It contains the ALU, the branch
// target adder, and the architectural HI/LO registers.
module mips_exec_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [1:0]  alu_op,
  input  logic [5:0]  opcode,
  input  logic [5:0]  function_code,
  input  logic [4:0]  shamt,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [31:0] immdt_32,
  input  logic [31:0] pc_plus4,
  output logic [31:0] alu_out,
  output logic        zero,
  output logic [31:0] branch_addr,
  output logic [31:0] hi_read,
  output logic [31:0] lo_read
);

  localparam logic [4:0] OP_NONE  = 5'd0;
  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_SLL   = 5'd3;
  localparam logic [4:0] OP_SRL   = 5'd4;
  localparam logic [4:0] OP_SRA   = 5'd5;
  localparam logic [4:0] OP_SLLV  = 5'd6;
  localparam logic [4:0] OP_SRLV  = 5'd7;
  localparam logic [4:0] OP_SRAV  = 5'd8;
  localparam logic [4:0] OP_MFHI  = 5'd9;
  localparam logic [4:0] OP_MFLO  = 5'd10;
  localparam logic [4:0] OP_MTHI  = 5'd11;
  localparam logic [4:0] OP_MTLO  = 5'd12;
  localparam logic [4:0] OP_MULT  = 5'd13;
  localparam logic [4:0] OP_MULTU = 5'd14;
  localparam logic [4:0] OP_DIV   = 5'd15;
  localparam logic [4:0] OP_DIVU  = 5'd16;
  localparam logic [4:0] OP_AND   = 5'd17;
  localparam logic [4:0] OP_OR    = 5'd18;
  localparam logic [4:0] OP_XOR   = 5'd19;
  localparam logic [4:0] OP_NOR   = 5'd20;
  localparam logic [4:0] OP_SLT   = 5'd21;
  localparam logic [4:0] OP_SLTU  = 5'd22;
  localparam logic [4:0] OP_LUI   = 5'd23;

  logic [4:0]         op;
  logic [31:0]        hi_q, lo_q;
  logic [31:0]        hi_next, lo_next;
  logic               hi_we, lo_we;
  logic [63:0]        prod_s, prod_u;
  logic               div_by_zero, div_ovf;
  logic [31:0]        div_s_b, div_u_b;
  logic signed [31:0] quot_s, rem_s;
  logic [31:0]        quot_u, rem_u;

  always_comb begin
    op = OP_NONE;
    case (alu_op)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b10: begin
        case (function_code)
          6'h00: op = OP_SLL;
          6'h02: op = OP_SRL;
          6'h03: op = OP_SRA;
          6'h04: op = OP_SLLV;
          6'h06: op = OP_SRLV;
          6'h07: op = OP_SRAV;
          6'h10: op = OP_MFHI;
          6'h11: op = OP_MTHI;
          6'h12: op = OP_MFLO;
          6'h13: op = OP_MTLO;
          6'h18: op = OP_MULT;
          6'h19: op = OP_MULTU;
          6'h1A: op = OP_DIV;
          6'h1B: op = OP_DIVU;
          6'h21: op = OP_ADD;
          6'h23: op = OP_SUB;
          6'h24: op = OP_AND;
          6'h25: op = OP_OR;
          6'h26: op = OP_XOR;
          6'h27: op = OP_NOR;
          6'h2A: op = OP_SLT;
          6'h2B: op = OP_SLTU;
          default: op = OP_NONE;
        endcase
      end
      default: begin
        case (opcode)
          6'h09: op = OP_ADD;
          6'h0A: op = OP_SLT;
          6'h0B: op = OP_SLTU;
          6'h0C: op = OP_AND;
          6'h0D: op = OP_OR;
          6'h0E: op = OP_XOR;
          6'h0F: op = OP_LUI;
          default: op = OP_NONE;
        endcase
      end
    endcase
  end

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};

  // Zero and overflow divisors are swapped for 1 so the divider never sees them; results are then patched
  assign div_by_zero = (B == 32'd0);
  assign div_ovf     = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
  assign div_s_b     = (div_by_zero || div_ovf) ? 32'd1 : B;
  assign div_u_b     = div_by_zero ? 32'd1 : B;
  assign quot_s      = $signed(A) / $signed(div_s_b);
  assign rem_s       = $signed(A) % $signed(div_s_b);
  assign quot_u      = A / div_u_b;
  assign rem_u       = A % div_u_b;

  always_comb begin
    alu_out = 32'd0;
    case (op)
      OP_ADD:  alu_out = A + B;
      OP_SUB:  alu_out = A - B;
      OP_SLL:  alu_out = B << shamt;
      OP_SRL:  alu_out = B >> shamt;
      OP_SRA:  alu_out = $unsigned($signed(B) >>> shamt);
      OP_SLLV: alu_out = B << A[4:0];
      OP_SRLV: alu_out = B >> A[4:0];
      OP_SRAV: alu_out = $unsigned($signed(B) >>> A[4:0]);
      OP_MFHI: alu_out = hi_q;
      OP_MFLO: alu_out = lo_q;
      OP_AND:  alu_out = A & B;
      OP_OR:   alu_out = A | B;
      OP_XOR:  alu_out = A ^ B;
      OP_NOR:  alu_out = ~(A | B);
      OP_SLT:  alu_out = {31'd0, $signed(A) < $signed(B)};
      OP_SLTU: alu_out = {31'd0, A < B};
      OP_LUI:  alu_out = {B[15:0], 16'd0};
      default: alu_out = 32'd0;
    endcase
  end

  assign zero        = (alu_out == 32'd0);
  assign branch_addr = pc_plus4 + {immdt_32[29:0], 2'b00};

  always_comb begin
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    hi_next = hi_q;
    lo_next = lo_q;
    case (op)
      OP_MTHI: begin
        hi_we   = 1'b1;
        hi_next = A;
      end
      OP_MTLO: begin
        lo_we   = 1'b1;
        lo_next = A;
      end
      OP_MULT: begin
        hi_we   = 1'b1;
        lo_we   = 1'b1;
        hi_next = prod_s[63:32];
        lo_next = prod_s[31:0];
      end
      OP_MULTU: begin
        hi_we   = 1'b1;
        lo_we   = 1'b1;
        hi_next = prod_u[63:32];
        lo_next = prod_u[31:0];
      end
      OP_DIV: begin
        hi_we   = 1'b1;
        lo_we   = 1'b1;
        hi_next = div_by_zero ? A : $unsigned(rem_s);
        lo_next = div_by_zero ? 32'hFFFF_FFFF : $unsigned(quot_s);
      end
      OP_DIVU: begin
        hi_we   = 1'b1;
        lo_we   = 1'b1;
        hi_next = div_by_zero ? A : rem_u;
        lo_next = div_by_zero ? 32'hFFFF_FFFF : quot_u;
      end
      default: begin
        hi_we = 1'b0;
        lo_we = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (clk_enable) begin
      if (hi_we) hi_q <= hi_next;
      if (lo_we) lo_q <= lo_next;
    end
  end

  assign hi_read = hi_q;
  assign lo_read = lo_q;

endmodule

// File: tb/tb_mips_exec_unit.sv
// Scoreboard bench for mips_exec_unit: expected values are queued as stimulus
// is driven, then popped and compared once the outputs settle.
module tb_mips_exec_unit;

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic [1:0]  alu_op;
  logic [5:0]  opcode;
  logic [5:0]  function_code;
  logic [4:0]  shamt;
  logic [31:0] A, B, immdt_32, pc_plus4;
  logic [31:0] alu_out, branch_addr, hi_read, lo_read;
  logic        zero;

  int tests_run = 0;
  int tests_failed = 0;

  localparam int K_ALU = 0;
  localparam int K_ZERO = 1;
  localparam int K_BR = 2;
  localparam int K_HI = 3;
  localparam int K_LO = 4;

  typedef struct {
    int          kind;
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t sb[$];

  mips_exec_unit dut (
    .clk(clk),
    .reset(reset),
    .clk_enable(clk_enable),
    .alu_op(alu_op),
    .opcode(opcode),
    .function_code(function_code),
    .shamt(shamt),
    .A(A),
    .B(B),
    .immdt_32(immdt_32),
    .pc_plus4(pc_plus4),
    .alu_out(alu_out),
    .zero(zero),
    .branch_addr(branch_addr),
    .hi_read(hi_read),
    .lo_read(lo_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic push_exp(input int kind, input string tag, input logic [31:0] value);
    exp_t e;
    e.kind  = kind;
    e.tag   = tag;
    e.value = value;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_ALU:   obs = alu_out;
        K_ZERO:  obs = {31'd0, zero};
        K_BR:    obs = branch_addr;
        K_HI:    obs = hi_read;
        default: obs = lo_read;
      endcase
      check_output(e.tag, obs, e.value);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] op, input logic [5:0] opc, input logic [5:0] fn,
                                input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    alu_op        = op;
    opcode        = opc;
    function_code = fn;
    shamt         = sh;
    A             = a;
    B             = b;
  endtask

  task automatic comb_check(input string tag, input logic [1:0] op, input logic [5:0] opc,
                            input logic [5:0] fn, input logic [4:0] sh, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_out);
    apply_stimulus(op, opc, fn, sh, a, b);
    push_exp(K_ALU, tag, exp_out);
    push_exp(K_ZERO, {tag, "_zero"}, {31'd0, exp_out == 32'd0});
    #1;
    drain();
  endtask

  task automatic hilo_check(input string tag, input logic [5:0] fn, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    apply_stimulus(2'b10, 6'h00, fn, 5'd0, a, b);
    push_exp(K_ALU, {tag, "_out"}, 32'd0);
    #1;
    drain();
    push_exp(K_HI, {tag, "_hi"}, exp_hi);
    push_exp(K_LO, {tag, "_lo"}, exp_lo);
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    reset = 1'b0;
    clk_enable = 1'b1;
    alu_op = 2'b00;
    opcode = 6'h00;
    function_code = 6'h00;
    shamt = 5'd0;
    A = 32'd0;
    B = 32'd0;
    immdt_32 = 32'd0;
    pc_plus4 = 32'd0;

    // An MTHI held across an edge must not land while reset is low
    apply_stimulus(2'b10, 6'h00, 6'h11, 5'd0, 32'hDEAD_BEEF, 32'd0);
    push_exp(K_HI, "reset_hi", 32'd0);
    push_exp(K_LO, "reset_lo", 32'd0);
    @(posedge clk);
    #1;
    drain();
    apply_stimulus(2'b00, 6'h00, 6'h00, 5'd0, 32'd0, 32'd0);
    reset = 1'b1;

    comb_check("addu", 2'b10, 6'h00, 6'h21, 5'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000);
    comb_check("subu", 2'b10, 6'h00, 6'h23, 5'd0, 32'd5, 32'd5, 32'd0);
    comb_check("op01_sub", 2'b01, 6'h00, 6'h00, 5'd0, 32'd3, 32'd3, 32'd0);
    comb_check("op00_add", 2'b00, 6'h00, 6'h3F, 5'd0, 32'h10, 32'h20, 32'h30);
    comb_check("slt", 2'b10, 6'h00, 6'h2A, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd1);
    comb_check("sltu", 2'b10, 6'h00, 6'h2B, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    comb_check("sra", 2'b10, 6'h00, 6'h03, 5'd4, 32'd0, 32'h8000_0000, 32'hF800_0000);
    comb_check("srlv", 2'b10, 6'h00, 6'h06, 5'd0, 32'd4, 32'h8000_0000, 32'h0800_0000);
    comb_check("sll", 2'b10, 6'h00, 6'h00, 5'd31, 32'd0, 32'd1, 32'h8000_0000);
    comb_check("nor", 2'b10, 6'h00, 6'h27, 5'd0, 32'h0F0F_0000, 32'h0000_00F0, 32'hF0F0_FF0F);
    comb_check("lui", 2'b11, 6'h0F, 6'h00, 5'd0, 32'd0, 32'h1234, 32'h1234_0000);
    comb_check("slti", 2'b11, 6'h0A, 6'h00, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'd1);
    comb_check("xori", 2'b11, 6'h0E, 6'h00, 5'd0, 32'hFF00_FF00, 32'h0000_FFFF, 32'hFF00_00FF);
    comb_check("undef_fn", 2'b10, 6'h00, 6'h3F, 5'd0, 32'h1234, 32'h5678, 32'd0);
    comb_check("undef_opc", 2'b11, 6'h3F, 6'h00, 5'd0, 32'h1234, 32'h5678, 32'd0);

    @(negedge clk);
    pc_plus4 = 32'hBFC0_0004;
    immdt_32 = 32'hFFFF_FFFF;
    push_exp(K_BR, "branch_back", 32'hBFC0_0000);
    #1;
    drain();
    immdt_32 = 32'h10;
    push_exp(K_BR, "branch_fwd", 32'hBFC0_0044);
    #1;
    drain();

    hilo_check("mult", 6'h18, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    comb_check("mfhi_mult", 2'b10, 6'h00, 6'h10, 5'd0, 32'd0, 32'd0, 32'hFFFF_FFFF);
    hilo_check("multu", 6'h19, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA);
    comb_check("mflo", 2'b10, 6'h00, 6'h12, 5'd0, 32'd0, 32'd0, 32'hFFFF_FFFA);
    comb_check("mfhi", 2'b10, 6'h00, 6'h10, 5'd0, 32'd0, 32'd0, 32'h0000_0002);
    hilo_check("div", 6'h1A, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    hilo_check("divu_zero", 6'h1B, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    hilo_check("div_ovf", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    hilo_check("divu", 6'h1B, 32'd100, 32'd7, 32'd2, 32'd14);
    hilo_check("mthi", 6'h11, 32'hAAAA_5555, 32'd0, 32'hAAAA_5555, 32'd14);
    hilo_check("mtlo", 6'h13, 32'h1234_5678, 32'd0, 32'hAAAA_5555, 32'h1234_5678);

    apply_stimulus(2'b00, 6'h00, 6'h00, 5'd0, 32'd0, 32'd0);
    clk_enable = 1'b0;
    hilo_check("mult_frozen", 6'h18, 32'd3, 32'd3, 32'hAAAA_5555, 32'h1234_5678);
    comb_check("frozen_addu", 2'b10, 6'h00, 6'h21, 5'd0, 32'd2, 32'd3, 32'd5);
    clk_enable = 1'b1;

    // Reset asserted between edges must clear HI/LO without waiting for a clock
    @(posedge clk);
    #2;
    reset = 1'b0;
    push_exp(K_HI, "async_reset_hi", 32'd0);
    push_exp(K_LO, "async_reset_lo", 32'd0);
    #1;
    drain();
    @(negedge clk);
    reset = 1'b1;
    hilo_check("mult_after_reset", 6'h18, 32'd6, 32'd7, 32'd0, 32'd42);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mips_exec_unit.md
# mips_exec_unit

Execute stage of the single-cycle MIPS CPU: decodes `alu_op`/opcode/function code into an internal ALU operation, computes the 32-bit result and zero flag, and computes the PC-relative branch target. It also holds the architectural HI/LO registers, which are written by multiply, divide, MTHI and MTLO. It sits between the register file/immediate mux and the branch/writeback muxes.

## Interface
- No parameters.
- `clk` input 1: rising-edge clock, used only by HI/LO.
- `reset` input 1: asynchronous, active-low; clears HI/LO.
- `clk_enable` input 1: HI/LO update only when 1.
- `alu_op` input 2: from control.
  - 00 = add (load/store address).
  - 01 = subtract (branch compare).
  - 10 = R-type, decode `function_code`.
  - 11 = I-type, decode `opcode`.
- `opcode` input 6: instr[31:26].
- `function_code` input 6: instr[5:0].
- `shamt` input 5: instr[10:6].
- `A` input 32: rs data.
- `B` input 32: rt data or extended immediate (already muxed).
- `immdt_32` input 32: extended immediate for the branch offset.
- `pc_plus4` input 32: PC+4.
- `alu_out` output 32: result.
- `zero` output 1: `alu_out == 0`.
- `branch_addr` output 32: branch target.
- `hi_read`, `lo_read` output 32: current HI/LO register values.

## Operation
- `alu_op` 00 gives A+B. `alu_op` 01 gives A−B.
- R-type operations (function code, hex):
  - Shifts, shifting B: 00 SLL by shamt, 02 SRL, 03 SRA; 04 SLLV by A[4:0], 06 SRLV, 07 SRAV.
  - HI/LO moves: 10 MFHI (out = HI), 12 MFLO (out = LO), 11 MTHI, 13 MTLO.
  - Multiply/divide: 18 MULT, 19 MULTU, 1A DIV, 1B DIVU.
  - Arithmetic/logic: 21 ADDU, 23 SUBU, 24 AND, 25 OR, 26 XOR, 27 NOR.
  - Compare: 2A SLT (signed), 2B SLTU (unsigned); result is 1 or 0.
- I-type operations (opcode, hex): 09 ADDIU, 0A SLTI, 0B SLTIU, 0C ANDI, 0D ORI, 0E XORI, 0F LUI (out = B<<16).
- Undefined codes: `alu_out` = 0, no HI/LO write.
- All add/subtract wraps modulo 2^32; overflow is never flagged.
- MULT/MULTU: 64-bit product, signed or unsigned. HI gets [63:32], LO gets [31:0].
- DIV/DIVU: LO gets quotient, HI gets remainder.
  - Signed division truncates toward zero; the remainder takes the dividend's sign.
  - Divisor 0: LO = FFFFFFFF, HI = A.
  - 80000000 / FFFFFFFF (signed): LO = 80000000, HI = 0.
- MTHI: HI gets A. MTLO: LO gets A. The other register is unchanged.
- Mult/div/MTHI/MTLO drive `alu_out` = 0.
- `branch_addr` = `pc_plus4` + (`immdt_32` << 2), wrapping modulo 2^32. It is always computed, independent of `alu_op`.

## Timing
- `alu_out`, `zero`, `branch_addr` are purely combinational; no latency.
- HI/LO update on the rising `clk` edge when `clk_enable`=1, `reset`=1 and a writing operation is decoded.
- `reset` low asynchronously forces HI = LO = 0 regardless of clock. While reset is held, no writes occur.
- `hi_read`/`lo_read` show the registered values.
- MFHI/MFLO in the same cycle as a write return the old value; the new value is visible the cycle after the edge.
- `clk_enable`=0 freezes HI/LO; combinational outputs still track inputs.

## Test plan
- ADDU A=7FFFFFFF, B=1 → `alu_out`=80000000, `zero`=0. SUBU A=B=5 → `alu_out`=0, `zero`=1. `alu_op`=01 with A=3, B=3 → `zero`=1.
- SLT A=FFFFFFFF, B=1 → 1. SLTU same operands → 0. SRA B=80000000 shamt=4 → F8000000. SRLV A=4, B=80000000 → 08000000. LUI B=1234 → 12340000.
- MULT A=FFFFFFFE, B=3 → after edge HI=FFFFFFFF, LO=FFFFFFFA. MULTU same operands → HI=2, LO=FFFFFFFA. MFLO the next cycle → `alu_out`=FFFFFFFA.
- DIV A=FFFFFFF9 (−7), B=2 → LO=FFFFFFFD, HI=FFFFFFFF. DIVU A=7, B=0 → LO=FFFFFFFF, HI=7.
- `pc_plus4`=BFC00004, `immdt_32`=FFFFFFFF → `branch_addr`=BFC00000. `immdt_32`=10 → BFC00044.
- MTHI A=AAAA5555 → HI=AAAA5555, LO unchanged. Drive `reset` low mid-cycle → HI=LO=0 immediately. With `clk_enable`=0, MULT produces no change.
